// File: rtl/axi_line_pkg.sv
// Shared types and AXI encodings for the cache line refill/writeback engine.
package axi_line_pkg;

    localparam int         LINE_BEATS     = 8;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

endpackage

// File: rtl/axi_line_ctl_line_buf.sv
// 8 x 64-bit line buffer: one synchronous write port shared by the cache fifo
// and the R channel, one asynchronous read port for W beats and refill output.
module line_buf
    import axi_line_pkg::*;
(
    input  logic        clk,
    input  logic        fifo_we,
    input  logic [2:0]  fifo_idx,
    input  logic [63:0] fifo_data,
    input  logic        r_we,
    input  logic [2:0]  r_idx,
    input  logic [63:0] r_data,
    input  logic [2:0]  rd_idx,
    output logic [63:0] rd_data
);

    logic [63:0] mem_q [LINE_BEATS];
    logic        we;
    logic [2:0]  widx;
    logic [63:0] wdat;

    // The two write sources are mutually exclusive: the controller blocks fifo writes during R.
    always_comb begin
        we   = r_we | fifo_we;
        widx = r_we ? r_idx  : fifo_idx;
        wdat = r_we ? r_data : fifo_data;
    end

    // NOTE: storage is deliberately not reset; contents are always written before being read.
    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= wdat;
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/axi_line_ctl.sv
// Line refill/writeback engine: cache-side request handshake, AXI4 master
// toward memory, one 64-byte line in flight at a time.
module axi_line_ctl
    import axi_line_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEATS  = LINE_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rw,
    input  logic [63:0]       req_addr,
    input  logic              fifo_wen,
    input  logic [63:0]       fifo_data,
    input  logic              fifo_done,
    output logic              done,
    output logic [63:0]       data_o,
    output logic              err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
);

    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [3:0] PTR_FULL  = 4'(BEATS);

    state_e            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [3:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              fifo_we, r_we;
    logic [63:0]       buf_rd;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[63:ADDR_W], req_addr[5:0]};

    // beat_q indexes W beats, R beats and, in DONE, the refill read-out position.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        addr_d   = addr_q;
        err_d    = err_q;
        fifo_we  = fifo_wen && (state_q != ST_R) && (wr_ptr_q != PTR_FULL);
        r_we     = (state_q == ST_R) && rvalid;

        if (fifo_we) wr_ptr_d = wr_ptr_q + 4'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (req && !fifo_done) begin
                    addr_d  = {req_addr[ADDR_W-1:6], 6'b0};
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = rw ? ST_AW : ST_AR;
                end
            end
            ST_AW: if (awready) state_d = ST_W;
            ST_W: begin
                if (wready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    beat_d  = '0;
                    state_d = ST_DONE;
                end
            end
            ST_AR: if (arready) state_d = ST_R;
            ST_R: begin
                if (rvalid) begin
                    beat_d = beat_q + 3'd1;
                    // rlast must coincide exactly with the eighth beat
                    if ((rresp != AXI_RESP_OKAY) || (rlast != (beat_q == LAST_BEAT))) err_d = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (fifo_done) begin
                    beat_d   = '0;
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end else if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    line_buf u_line_buf (
        .clk       (clk),
        .fifo_we   (fifo_we),
        .fifo_idx  (wr_ptr_q[2:0]),
        .fifo_data (fifo_data),
        .r_we      (r_we),
        .r_idx     (beat_q),
        .r_data    (rdata),
        .rd_idx    (beat_q),
        .rd_data   (buf_rd)
    );

    assign awvalid = (state_q == ST_AW);
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN_LINE;
    assign awsize  = AXI_SIZE_8B;
    assign awburst = AXI_BURST_INCR;

    assign wvalid  = (state_q == ST_W);
    assign wdata   = wvalid ? buf_rd : '0;
    assign wstrb   = 8'hFF;
    assign wlast   = wvalid && (beat_q == LAST_BEAT);

    assign bready  = (state_q == ST_B);

    assign arvalid = (state_q == ST_AR);
    assign araddr  = addr_q;
    assign arlen   = AXI_LEN_LINE;
    assign arsize  = AXI_SIZE_8B;
    assign arburst = AXI_BURST_INCR;

    assign rready  = (state_q == ST_R);

    assign done    = (state_q == ST_DONE);
    assign data_o  = done ? buf_rd : '0;
    assign err     = err_q;

endmodule
